downsample_core: RTL and testbench
==================================

Name: downsample_core

Overview:
- Processing engine that owns the image RAM while the design is in its processing phase.
- Reads an IMG_W x IMG_H 8-bit image from RAM base 0, computes a rounded 2x2 block average, and writes the (IMG_W/2) x (IMG_H/2) result to OUT_BASE.
- Generates the pro_work/pro_finish phase flags consumed by the RAM-port selection mux, and drives the proc_* RAM signals that the mux forwards.
- Runs entirely on proc_clk.

Parameters:
- IMG_W, 128, input image width in pixels (even, >=2)
- IMG_H, 128, input image height in pixels (even, >=2)
- OUT_BASE, 16'h4000, RAM byte address of output pixel (0,0)
- ADDR_W, 16, RAM address width
- DATA_W, 8, pixel width

Ports:
- proc_clk, input, 1, processing clock; all state is updated on its rising edge
- rst_n, input, 1, reset; asynchronous, active-low
- rx_done, input, 1, one-cycle pulse: UART reception of the full image is complete
- tx_done, input, 1, one-cycle pulse: UART transmission of the result is complete
- ram_dout, input, DATA_W, RAM read data; synchronous read, valid one cycle after proc_addr
- pro_work, output, 1, high from processing start until tx_done
- pro_finish, output, 1, high from processing end until tx_done
- proc_addr, output, ADDR_W, RAM address
- proc_din, output, DATA_W, RAM write data
- proc_write_EN, output, 1, RAM write strobe

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and accumulator 0. Reset takes effect immediately, mid-operation included: a write in flight is dropped and no partial state survives.
- Phase flags:
  - 00 = receive (IDLE)
  - 10 = processing (RD/LAST/WR)
  - 11 = transmit (DONE)
  - 01 is never produced.
- FSM states: IDLE, RD, LAST, WR, DONE.
- IDLE:
  - rx_done=1 -> RD with k=0; pro_work goes to 1 on the same edge. The first read address is therefore driven in the first cycle pro_work is high.
  - tx_done is ignored in IDLE.
- RD (k = 0..3, one cycle each):
  - Drive proc_addr = rowbase + 2x + off[k], where off = {0, 1, IMG_W, IMG_W+1}.
  - For k >= 1, add ram_dout (data from the k-1 address) into a 10-bit accumulator.
  - After k=3 -> LAST.
- LAST: add ram_dout (p11) to the accumulator; proc_addr holds its previous value -> WR.
- WR (one cycle):
  - proc_write_EN=1, proc_addr = out_addr, proc_din = (acc + 2) >> 2, truncated to 8 bits. Maximum is (1020+2)>>2 = 255, so no overflow.
  - Clear acc and advance: x++, out_addr++.
  - If x wraps at IMG_W/2: x=0, rowbase += 2*IMG_W, y++.
  - If y also wraps at IMG_H/2: -> DONE. Otherwise -> RD with k=0.
- Latency: 6 cycles per output pixel; total (IMG_W/2)*(IMG_H/2)*6 cycles from the rx_done edge to the pro_finish rise.
- DONE:
  - pro_work=1, pro_finish=1, proc_write_EN=0, proc_addr=0.
  - tx_done=1 -> IDLE; both flags drop on the same edge.
- proc_write_EN is high only in WR. Outside WR, proc_din=0.
- Address generation uses incrementers only; no multipliers.
- Simultaneous events:
  - rx_done during RD/LAST/WR/DONE is ignored.
  - rx_done together with tx_done in DONE: return to IDLE. No restart without a fresh rx_done.
  - Back-to-back runs: a new rx_done in IDLE restarts from pixel (0,0) with counters reset.

Decomposition:
- Shared package/include ds_defs:
  - FSM state encodings (IDLE=0, RD=1, LAST=2, WR=3, DONE=4)
  - phase-flag encodings 00/10/11
  - default IMG_W/IMG_H/OUT_BASE constants, shared with the UART stages
- Sub-module ds_addr_gen:
  - holds x/y counters, rowbase and out_addr
  - outputs the read address for k, the write address, and a last_pixel flag
- FSM, accumulator and rounding stay in downsample_core.

Test Plan:
- IMG_W=IMG_H=4, OUT_BASE=16, RAM model preloaded with addr i = i (i = 0..15); pulse rx_done -> RAM[16..19] = 3, 5, 11, 13. proc_write_EN pulses exactly 4 times.
- Same setup: pro_work rises on the edge sampling rx_done. pro_finish rises exactly 24 cycles later. No address outside 0..19 is ever driven.
- Rounding, 2x2 image, OUT_BASE=4:
  - all 255 -> 255
  - {0,0,0,1} -> 0
  - {0,0,1,1} -> 1
  - {0,1,1,1} -> 1
  - {1,1,1,2} -> 1
- In DONE, pulse rx_done -> no change. Then pulse tx_done -> pro_work = pro_finish = 0 on the next edge. Second rx_done -> identical results rewritten.
- Assert rst_n=0 mid-run, during WR of pixel 2 -> all outputs 0 immediately with no further writes. Release and pulse rx_done -> full correct run from pixel (0,0).
- tx_done pulses in IDLE and during RD -> ignored. Flags are never observed as pro_work=0 with pro_finish=1.

Source files
------------

// File: rtl/ds_defs_pkg.sv
// rtl/ds_defs_pkg.sv - shared state/phase encodings and default image geometry
package ds_defs_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAST = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // {pro_work, pro_finish}; 2'b01 is never produced
  localparam logic [1:0] PHASE_RX   = 2'b00;
  localparam logic [1:0] PHASE_PROC = 2'b10;
  localparam logic [1:0] PHASE_TX   = 2'b11;

  localparam int DEF_IMG_W    = 128;
  localparam int DEF_IMG_H    = 128;
  localparam int DEF_OUT_BASE = 'h4000;

endpackage

// File: rtl/ds_addr_gen.sv
// rtl/ds_addr_gen.sv - pixel-block counters and read/write address generation
module ds_addr_gen #(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 128,
  parameter int OUT_BASE = 'h4000,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [1:0]        k,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_pixel
);

  localparam int XW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
  localparam int YW = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;
  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W / 2 - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H / 2 - 1);
  localparam logic [ADDR_W-1:0] ROW_OFF  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] OUT_INIT = ADDR_W'(OUT_BASE);

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] rowbase_q, rowbase_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  // pix tracks rowbase + 2x so reads need only a constant offset
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    rowbase_d  = rowbase_q;
    pix_d      = pix_q;
    out_addr_d = out_addr_q;
    if (clear) begin
      x_d        = '0;
      y_d        = '0;
      rowbase_d  = '0;
      pix_d      = '0;
      out_addr_d = OUT_INIT;
    end else if (advance) begin
      out_addr_d = out_addr_q + ADDR_W'(1);
      if (x_q == X_LAST) begin
        x_d       = '0;
        rowbase_d = rowbase_q + ROW_STEP;
        pix_d     = rowbase_q + ROW_STEP;
        y_d       = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d   = x_q + XW'(1);
        pix_d = pix_q + ADDR_W'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      rowbase_q  <= '0;
      pix_q      <= '0;
      out_addr_q <= OUT_INIT;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      rowbase_q  <= rowbase_d;
      pix_q      <= pix_d;
      out_addr_q <= out_addr_d;
    end
  end

  always_comb begin
    rd_addr = pix_q;
    case (k)
      2'd0:    rd_addr = pix_q;
      2'd1:    rd_addr = pix_q + ADDR_W'(1);
      2'd2:    rd_addr = pix_q + ROW_OFF;
      default: rd_addr = pix_q + ROW_OFF + ADDR_W'(1);
    endcase
  end

  assign wr_addr    = out_addr_q;
  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/downsample_core.sv
// rtl/downsample_core.sv - 2x2 rounded block-average downsampler owning the image RAM
module downsample_core
  import ds_defs_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int OUT_BASE = DEF_OUT_BASE,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8
) (
  input  logic              proc_clk,
  input  logic              rst_n,
  input  logic              rx_done,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              pro_work,
  output logic              pro_finish,
  output logic [ADDR_W-1:0] proc_addr,
  output logic [DATA_W-1:0] proc_din,
  output logic              proc_write_EN
);

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [DATA_W+1:0]   acc_q, acc_d;
  logic                ag_clear, ag_advance, last_pixel;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic [1:0]          phase;

  ds_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .OUT_BASE(OUT_BASE),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk       (proc_clk),
    .rst_n     (rst_n),
    .clear     (ag_clear),
    .advance   (ag_advance),
    .k         (k_q),
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .last_pixel(last_pixel)
  );

  // Read data lags its address by one cycle, so RD k>=1 and LAST accumulate
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    acc_d         = acc_q;
    ag_clear      = 1'b0;
    ag_advance    = 1'b0;
    phase         = PHASE_RX;
    proc_addr     = '0;
    proc_din      = '0;
    proc_write_EN = 1'b0;
    case (state_q)
      S_IDLE: begin
        ag_clear = 1'b1;
        acc_d    = '0;
        k_d      = 2'd0;
        if (rx_done) state_d = S_RD;
      end
      S_RD: begin
        phase     = PHASE_PROC;
        proc_addr = rd_addr;
        if (k_q != 2'd0) acc_d = acc_q + {2'b00, ram_dout};
        if (k_q == 2'd3) state_d = S_LAST;
        else             k_d     = k_q + 2'd1;
      end
      S_LAST: begin
        phase     = PHASE_PROC;
        proc_addr = rd_addr;
        acc_d     = acc_q + {2'b00, ram_dout};
        state_d   = S_WR;
      end
      S_WR: begin
        phase         = PHASE_PROC;
        proc_write_EN = 1'b1;
        proc_addr     = wr_addr;
        proc_din      = DATA_W'((acc_q + (DATA_W + 2)'(2)) >> 2);
        acc_d         = '0;
        k_d           = 2'd0;
        ag_advance    = 1'b1;
        state_d       = last_pixel ? S_DONE : S_RD;
      end
      S_DONE: begin
        phase = PHASE_TX;
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge proc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  assign {pro_work, pro_finish} = phase;

endmodule

// File: tb/tb_downsample_core.sv
// tb/tb_downsample_core.sv - scoreboard bench for downsample_core (4x4 and 2x2 instances)
module tb_downsample_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        rx1, tx1, pw1, pf1, we1;
  logic [7:0]  dout1, din1;
  logic [15:0] addr1;
  logic        rx2, tx2, pw2, pf2, we2;
  logic [7:0]  dout2, din2;
  logic [15:0] addr2;

  downsample_core #(.IMG_W(4), .IMG_H(4), .OUT_BASE(16), .ADDR_W(16), .DATA_W(8)) dut1 (
    .proc_clk(clk), .rst_n(rst_n), .rx_done(rx1), .tx_done(tx1), .ram_dout(dout1),
    .pro_work(pw1), .pro_finish(pf1), .proc_addr(addr1), .proc_din(din1),
    .proc_write_EN(we1));

  downsample_core #(.IMG_W(2), .IMG_H(2), .OUT_BASE(4), .ADDR_W(16), .DATA_W(8)) dut2 (
    .proc_clk(clk), .rst_n(rst_n), .rx_done(rx2), .tx_done(tx2), .ram_dout(dout2),
    .pro_work(pw2), .pro_finish(pf2), .proc_addr(addr2), .proc_din(din2),
    .proc_write_EN(we2));

  logic [7:0] mem1 [0:31];
  logic [7:0] mem2 [0:7];
  logic       ld1, ld2;
  logic [4:0] lda1;
  logic [2:0] lda2;
  logic [7:0] ldd1, ldd2;

  always @(posedge clk) begin
    if (we1) mem1[addr1[4:0]] <= din1;
    if (ld1) mem1[lda1] <= ldd1;
    dout1 <= mem1[addr1[4:0]];
  end

  always @(posedge clk) begin
    if (we2) mem2[addr2[2:0]] <= din2;
    if (ld2) mem2[lda2] <= ldd2;
    dout2 <= mem2[addr2[2:0]];
  end

  int checks = 0;
  int errors = 0;
  int wr1 = 0;
  int wr2 = 0;
  logic [15:0] q1a[$];
  logic [7:0]  q1d[$];
  logic [15:0] q2a[$];
  logic [7:0]  q2d[$];
  logic [7:0]  img1 [16];
  logic [7:0]  img2 [4];
  int          exp1 [4];
  int          exp2;

  int ramp_exp [4]  = '{3, 5, 11, 13};
  int rc [5][4]     = '{'{255, 255, 255, 255}, '{0, 0, 0, 1}, '{0, 0, 1, 1},
                        '{0, 1, 1, 1}, '{1, 1, 1, 2}};
  int rc_exp [5]    = '{255, 0, 1, 1, 1};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int avg4(input int a, input int b, input int c, input int d);
    return (a + b + c + d + 2) / 4;
  endfunction

  // Monitors: pop the scoreboard on every write strobe and watch flags/address range
  initial forever begin
    @(negedge clk);
    chk("flags1_never_01", int'(!pw1 && pf1), 0);
    chk("addr1_in_range", int'(addr1 <= 16'd19), 1);
    if (we1) begin
      wr1++;
      if (q1a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write1: addr %0d data %0d, none expected", addr1, din1);
      end else begin
        chk("wr1_addr", int'(addr1), int'(q1a.pop_front()));
        chk("wr1_data", int'(din1), int'(q1d.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("flags2_never_01", int'(!pw2 && pf2), 0);
    chk("addr2_in_range", int'(addr2 <= 16'd4), 1);
    if (we2) begin
      wr2++;
      if (q2a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write2: addr %0d data %0d, none expected", addr2, din2);
      end else begin
        chk("wr2_addr", int'(addr2), int'(q2a.pop_front()));
        chk("wr2_data", int'(din2), int'(q2d.pop_front()));
      end
    end
  end

  task automatic load1();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); ld1 = 1'b1; lda1 = 5'(i); ldd1 = img1[i];
    end
    @(negedge clk); ld1 = 1'b0;
  endtask

  task automatic clear_out1(input logic [7:0] v);
    for (int i = 16; i < 20; i++) begin
      @(negedge clk); ld1 = 1'b1; lda1 = 5'(i); ldd1 = v;
    end
    @(negedge clk); ld1 = 1'b0;
  endtask

  task automatic push_expected1();
    for (int oy = 0; oy < 2; oy++) begin
      for (int ox = 0; ox < 2; ox++) begin
        int b;
        b = oy * 8 + ox * 2;
        exp1[oy * 2 + ox] = avg4(img1[b], img1[b + 1], img1[b + 4], img1[b + 5]);
        q1a.push_back(16'(16 + oy * 2 + ox));
        q1d.push_back(8'(exp1[oy * 2 + ox]));
      end
    end
  endtask

  task automatic run1(input bit tx_in_rd);
    int n;
    push_expected1();
    wr1 = 0;
    @(negedge clk); rx1 = 1'b1;
    @(posedge clk); #1 rx1 = 1'b0;
    chk("start_pro_work1", int'(pw1), 1);
    chk("start_pro_finish1", int'(pf1), 0);
    chk("start_addr1", int'(addr1), 0);
    n = 0;
    do begin
      if (tx_in_rd && n == 1) tx1 = 1'b1;
      @(posedge clk); #1 tx1 = 1'b0;
      n++;
    end while (!pf1 && n < 100);
    chk("latency1", n, 24);
    chk("writes1", wr1, 4);
    chk("sb_empty1", q1a.size(), 0);
    for (int j = 0; j < 4; j++) chk("ram_out1", int'(mem1[16 + j]), exp1[j]);
  endtask

  task automatic tx_exit1();
    @(negedge clk); tx1 = 1'b1;
    @(posedge clk); #1 tx1 = 1'b0;
    chk("tx_exit_work1", int'(pw1), 0);
    chk("tx_exit_finish1", int'(pf1), 0);
  endtask

  task automatic run2();
    int n;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ld2 = 1'b1; lda2 = 3'(i); ldd2 = img2[i];
    end
    @(negedge clk); ld2 = 1'b1; lda2 = 3'd4; ldd2 = 8'hEE;
    @(negedge clk); ld2 = 1'b0;
    exp2 = avg4(img2[0], img2[1], img2[2], img2[3]);
    q2a.push_back(16'd4);
    q2d.push_back(8'(exp2));
    wr2 = 0;
    @(negedge clk); rx2 = 1'b1;
    @(posedge clk); #1 rx2 = 1'b0;
    chk("start_pro_work2", int'(pw2), 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!pf2 && n < 100);
    chk("latency2", n, 6);
    chk("writes2", wr2, 1);
    chk("ram_out2", int'(mem2[4]), exp2);
    @(negedge clk); tx2 = 1'b1;
    @(posedge clk); #1 tx2 = 1'b0;
    chk("tx_exit_work2", int'(pw2), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    rx1 = 1'b0; tx1 = 1'b0; rx2 = 1'b0; tx2 = 1'b0;
    ld1 = 1'b0; ld2 = 1'b0; lda1 = '0; lda2 = '0; ldd1 = '0; ldd2 = '0;
    #1;
    chk("rst_pro_work", int'(pw1), 0);
    chk("rst_pro_finish", int'(pf1), 0);
    chk("rst_addr", int'(addr1), 0);
    chk("rst_din", int'(din1), 0);
    chk("rst_we", int'(we1), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // tx_done in IDLE is ignored
    @(negedge clk); tx1 = 1'b1;
    @(posedge clk); #1 tx1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_tx_ignored", int'(pw1), 0);

    // Ramp image, tx_done pulsed during RD
    for (int i = 0; i < 16; i++) img1[i] = 8'(i);
    load1();
    clear_out1(8'hEE);
    run1(1'b1);
    for (int j = 0; j < 4; j++) chk("ramp_out", int'(mem1[16 + j]), ramp_exp[j]);

    // rx_done in DONE is ignored
    @(negedge clk); rx1 = 1'b1;
    @(posedge clk); #1 rx1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_rx_work", int'(pw1), 1);
    chk("done_rx_finish", int'(pf1), 1);
    chk("done_rx_no_writes", wr1, 4);
    tx_exit1();

    // Back-to-back run rewrites identical results
    clear_out1(8'h00);
    run1(1'b0);
    for (int j = 0; j < 4; j++) chk("rerun_out", int'(mem1[16 + j]), ramp_exp[j]);

    // rx_done together with tx_done in DONE returns to IDLE without restart
    @(negedge clk); rx1 = 1'b1; tx1 = 1'b1;
    @(posedge clk); #1 rx1 = 1'b0; tx1 = 1'b0;
    chk("rxtx_work", int'(pw1), 0);
    chk("rxtx_finish", int'(pf1), 0);
    repeat (6) @(posedge clk);
    #1 chk("rxtx_no_restart", int'(pw1), 0);

    // Random images
    repeat (3) begin
      for (int i = 0; i < 16; i++) img1[i] = 8'($urandom_range(0, 255));
      load1();
      clear_out1(8'hEE);
      run1(1'b0);
      tx_exit1();
    end

    // Reset during the write of pixel 2
    for (int i = 0; i < 16; i++) img1[i] = 8'($urandom_range(0, 255));
    load1();
    clear_out1(8'hEE);
    push_expected1();
    wr1 = 0;
    @(negedge clk); rx1 = 1'b1;
    @(posedge clk); #1 rx1 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(we1 && wr1 == 2) && n < 100);
    chk("rst_reached_wr2", int'(we1 && wr1 == 2), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_work", int'(pw1), 0);
    chk("midrst_finish", int'(pf1), 0);
    chk("midrst_addr", int'(addr1), 0);
    chk("midrst_din", int'(din1), 0);
    chk("midrst_we", int'(we1), 0);
    q1a.delete();
    q1d.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_writes", wr1, 2);
    chk("midrst_px0", int'(mem1[16]), exp1[0]);
    chk("midrst_px1", int'(mem1[17]), exp1[1]);
    chk("midrst_px2_dropped", int'(mem1[18]), 'hEE);
    chk("midrst_px3_dropped", int'(mem1[19]), 'hEE);
    rst_n = 1'b1;
    clear_out1(8'hEE);
    run1(1'b0);
    tx_exit1();

    // Rounding on the minimum 2x2 image
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) img2[i] = 8'(rc[c][i]);
      run2();
      chk("round_case", int'(mem2[4]), rc_exp[c]);
    end
    repeat (4) begin
      for (int i = 0; i < 4; i++) img2[i] = 8'($urandom_range(0, 255));
      run2();
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
